// File: rtl/cs_loader.sv
// cs_loader: copies microcode from the EPROM into control store RAM at
// power-up or on request, optionally reading each word back to verify it.
module cs_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ROM_WAIT   = 2,
    parameter int unsigned VERIFY     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reload,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [ADDR_WIDTH-1:0] cs_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram__w,
    output logic                  own_bus,
    output logic                  cs_ready,
    output logic                  load_error,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_WAIT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                r_state;
    logic [WAIT_W-1:0]     r_wait;
    logic [ADDR_WIDTH-1:0] r_cs_addr;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_ram_w;
    logic                  r_own_bus;
    logic                  r_cs_ready;
    logic                  r_load_error;
    logic [ADDR_WIDTH-1:0] r_err_addr;

    logic w_adv;
    logic w_last;

    // Word is finished: written with no verify, or read back intact.
    assign w_adv  = ((r_state == S_WRITE) && (VERIFY == 32'd0)) ||
                    ((r_state == S_CHECK) && (ram_rdata == r_word));
    assign w_last = (r_cs_addr == '1);

    // Copy sequencer: fetch, write, optional check, then advance or stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_wait       <= '0;
            r_cs_addr    <= '0;
            r_word       <= '0;
            r_ram_w      <= 1'b1;
            r_own_bus    <= 1'b1;
            r_cs_ready   <= 1'b0;
            r_load_error <= 1'b0;
            r_err_addr   <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_wait == WAIT_LAST) begin
                        r_word  <= rom_data;
                        r_ram_w <= 1'b0;
                        r_state <= S_WRITE;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_WRITE: begin
                    r_ram_w <= 1'b1;
                    if (VERIFY != 32'd0) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (ram_rdata != r_word) begin
                        r_state      <= S_ERROR;
                        r_load_error <= 1'b1;
                        r_err_addr   <= r_cs_addr;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (reload) begin
                        r_state      <= S_FETCH;
                        r_wait       <= '0;
                        r_cs_addr    <= '0;
                        r_own_bus    <= 1'b1;
                        r_cs_ready   <= 1'b0;
                        r_load_error <= 1'b0;
                        r_err_addr   <= '0;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase

            // The last address stops the copy rather than wrapping to zero.
            if (w_adv) begin
                if (w_last) begin
                    r_state    <= S_DONE;
                    r_cs_ready <= 1'b1;
                    r_own_bus  <= 1'b0;
                end else begin
                    r_cs_addr <= r_cs_addr + ADDR_WIDTH'(1);
                    r_wait    <= '0;
                    r_state   <= S_FETCH;
                end
            end
        end
    end

    assign cs_addr    = r_cs_addr;
    assign ram_wdata  = r_word;
    assign ram__w     = r_ram_w;
    assign own_bus    = r_own_bus;
    assign cs_ready   = r_cs_ready;
    assign load_error = r_load_error;
    assign err_addr   = r_err_addr;

endmodule

// File: tb/tb_cs_loader.sv
// Bench for cs_loader: a default-parameter instance and a no-verify,
// single-wait instance, each with its own RAM model and a shared ROM image.
module tb_cs_loader;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 64;
    localparam int unsigned N  = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic reload_a = 1'b0;
    logic corrupt_a = 1'b0;

    logic [AW-1:0] a_addr, a_err_addr, b_addr, b_err_addr;
    logic [DW-1:0] a_rom, a_rdata, a_wdata, b_rom, b_rdata, b_wdata;
    logic a_ramw, a_own, a_ready, a_err;
    logic b_ramw, b_own, b_ready, b_err;

    logic [DW-1:0] rom_mem [N];
    logic [DW-1:0] ram_a   [N];
    logic [DW-1:0] ram_b   [N];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit sel = 1'b0;
    int t0;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } pulse_t;
    pulse_t pq[$];

    localparam logic [DW-1:0] BIT63 = {1'b1, {(DW-1){1'b0}}};

    assign a_rom   = rom_mem[a_addr];
    assign b_rom   = rom_mem[b_addr];
    assign a_rdata = ram_a[a_addr] ^ ((corrupt_a && a_addr == 8'h5A) ? BIT63 : '0);
    assign b_rdata = ram_b[b_addr] ^ BIT63;

    cs_loader u_a (
        .clk(clk), .reset(rst_a), .reload(reload_a),
        .rom_data(a_rom), .ram_rdata(a_rdata),
        .cs_addr(a_addr), .ram_wdata(a_wdata), .ram__w(a_ramw),
        .own_bus(a_own), .cs_ready(a_ready), .load_error(a_err),
        .err_addr(a_err_addr)
    );

    cs_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .ROM_WAIT(1), .VERIFY(0)) u_b (
        .clk(clk), .reset(rst_b), .reload(1'b0),
        .rom_data(b_rom), .ram_rdata(b_rdata),
        .cs_addr(b_addr), .ram_wdata(b_wdata), .ram__w(b_ramw),
        .own_bus(b_own), .cs_ready(b_ready), .load_error(b_err),
        .err_addr(b_err_addr)
    );

    // Selected-instance view used by the copy checker.
    logic [AW-1:0] m_addr, m_err_addr;
    logic m_ready, m_err, m_own, m_ramw;
    assign m_addr     = sel ? b_addr : a_addr;
    assign m_err_addr = sel ? b_err_addr : a_err_addr;
    assign m_ready    = sel ? b_ready : a_ready;
    assign m_err      = sel ? b_err : a_err;
    assign m_own      = sel ? b_own : a_own;
    assign m_ramw     = sel ? b_ramw : a_ramw;

    // RAM models and edge counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_ramw == 1'b0) ram_a[a_addr] <= a_wdata;
        if (b_ramw == 1'b0) ram_b[b_addr] <= b_wdata;
    end

    // Log every write-strobe cycle of the selected instance.
    always @(negedge clk) begin
        if (m_ramw == 1'b0)
            pq.push_back('{cyc, m_addr, sel ? b_wdata : a_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the copy to finish or stop, then compare against the model:
    // word j is strobed at t0 + j*pw + rw, completion at t0 + 256*pw,
    // a failing word k stops the copy at t0 + k*pw + pw.
    task automatic run_copy(input int start, input int pw, input int rw, input int err_at);
        logic own_bad;
        int bad;
        int lim;
        own_bad = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (m_ready || m_err) break;
            if (!m_own) own_bad = 1'b1;
        end
        check("own_bus_during_copy", 64'(own_bad), 64'd0);
        if (err_at < 0) begin
            lim = N;
            check("ready_cycle", 64'(cyc), 64'(start + N * pw));
            check("own_bus_at_done", 64'(m_own), 64'd0);
            check("load_error_at_done", 64'(m_err), 64'd0);
            check("addr_at_done", 64'(m_addr), 64'hFF);
        end else begin
            lim = err_at + 1;
            check("error_cycle", 64'(cyc), 64'(start + err_at * pw + pw));
            check("err_addr", 64'(m_err_addr), 64'(err_at));
            check("addr_in_error", 64'(m_addr), 64'(err_at));
            check("ready_in_error", 64'(m_ready), 64'd0);
            check("own_bus_in_error", 64'(m_own), 64'd1);
        end
        check("pulse_count", 64'(pq.size()), 64'(lim));
        for (int j = 0; j < pq.size() && j < lim; j++) begin
            check("pulse_cycle", 64'(pq[j].c), 64'(start + j * pw + rw));
            check("pulse_addr", 64'(pq[j].a), 64'(j));
            check("pulse_data", pq[j].d, rom_mem[j]);
        end
        bad = 0;
        for (int k = 0; k < lim; k++)
            if ((sel ? ram_b[k] : ram_a[k]) !== rom_mem[k]) bad++;
        check("ram_contents", 64'(bad), 64'd0);
    endtask

    task automatic randomize_rom();
        for (int k = 0; k < N; k++) rom_mem[k] = {$urandom(), $urandom()};
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            ram_a[k] = '0;
            ram_b[k] = '0;
            rom_mem[k] = 64'(k);
        end
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_addr", 64'(a_addr), 64'd0);
        check("rst_ram_w", 64'(a_ramw), 64'd1);
        check("rst_own_bus", 64'(a_own), 64'd1);
        check("rst_ready", 64'(a_ready), 64'd0);
        check("rst_load_error", 64'(a_err), 64'd0);
        check("rst_err_addr", 64'(a_err_addr), 64'd0);
        check("rst_wdata", a_wdata, 64'd0);

        // Identity image, default timing.
        sel = 1'b0;
        pq.delete();
        rst_a = 1'b0;
        t0 = cyc;
        run_copy(t0, 4, 2, -1);

        // Reload from DONE with a random image and a bad RAM bit at 0x5A.
        randomize_rom();
        corrupt_a = 1'b1;
        reload_a = 1'b1;
        @(negedge clk);
        reload_a = 1'b0;
        t0 = cyc;
        pq.delete();
        check("reload_done_clears_ready", 64'(a_ready), 64'd0);
        check("reload_done_addr", 64'(a_addr), 64'd0);
        check("reload_done_own_bus", 64'(a_own), 64'd1);
        run_copy(t0, 4, 2, 8'h5A);
        repeat (10) @(negedge clk);
        check("no_writes_after_error", 64'(pq.size()), 64'h5B);
        check("error_holds", 64'(a_err), 64'd1);
        check("err_addr_holds", 64'(a_err_addr), 64'h5A);

        // Fix the RAM and pulse reload once.
        corrupt_a = 1'b0;
        randomize_rom();
        reload_a = 1'b1;
        @(negedge clk);
        reload_a = 1'b0;
        t0 = cyc;
        pq.delete();
        check("reload_err_clears_error", 64'(a_err), 64'd0);
        check("reload_err_clears_err_addr", 64'(a_err_addr), 64'd0);
        check("reload_err_addr", 64'(a_addr), 64'd0);
        run_copy(t0, 4, 2, -1);

        // Reload held high across a whole copy must not disturb timing.
        randomize_rom();
        reload_a = 1'b1;
        @(negedge clk);
        t0 = cyc;
        pq.delete();
        run_copy(t0, 4, 2, -1);
        reload_a = 1'b0;
        @(negedge clk);
        check("ready_stays_after_held_reload", 64'(a_ready), 64'd1);

        // Reset partway through a copy, then a full copy after release.
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        randomize_rom();
        repeat (500) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        check("midreset_addr", 64'(a_addr), 64'd0);
        check("midreset_ram_w", 64'(a_ramw), 64'd1);
        check("midreset_own_bus", 64'(a_own), 64'd1);
        check("midreset_ready", 64'(a_ready), 64'd0);
        pq.delete();
        rst_a = 1'b0;
        t0 = cyc;
        run_copy(t0, 4, 2, -1);

        // No-verify instance: two cycles per word, corruption never flagged.
        sel = 1'b1;
        pq.delete();
        rst_b = 1'b0;
        t0 = cyc;
        run_copy(t0, 2, 1, -1);
        repeat (3) @(negedge clk);
        check("noverify_load_error", 64'(b_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
